// File: rtl/result_dump_reader_pkg.sv
// Shared definitions for the result dump reader: FSM states, byte-split
// constants and address-geometry defaults common with the data memory.
package result_dump_reader_pkg;

    localparam int ADDR_W_DEF     = 12;
    localparam int ROW_STRIDE_DEF = 64;
    localparam int DIM_W_DEF      = 7;
    localparam int WORD_W         = 12;

    localparam logic [3:0] HI_PAD = 4'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_SEND_HI,
        S_SEND_LO,
        S_ADVANCE,
        S_FINISH
    } state_t;

endpackage

// File: rtl/result_dump_reader_dump_addr_gen.sv
// Row/column walker for the dump region: latches geometry on load, registers
// the element address on issue and steps column-first on advance.
module dump_addr_gen #(
    parameter int ADDR_W     = 12,
    parameter int DIM_W      = 7,
    parameter int ROW_STRIDE = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [DIM_W-1:0]  rows_in,
    input  logic [DIM_W-1:0]  cols_in,
    input  logic              issue,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last_elem
);
    import result_dump_reader_pkg::*;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [DIM_W-1:0]  r_q, r_d;
    logic [DIM_W-1:0]  c_q, c_d;

    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] elem_addr;
    logic              last_col;
    logic              last_row;

    // Row offset and sum are kept at ADDR_W so the address wraps naturally.
    assign row_off   = ADDR_W'(r_q) * ADDR_W'(ROW_STRIDE);
    assign elem_addr = base_q + row_off + ADDR_W'(c_q);
    assign last_col  = (c_q == cols_q - DIM_W'(1));
    assign last_row  = (r_q == rows_q - DIM_W'(1));
    assign last_elem = last_col && last_row;
    assign addr      = addr_q;

    always_comb begin
        base_d = base_q;
        rows_d = rows_q;
        cols_d = cols_q;
        r_d    = r_q;
        c_d    = c_q;
        addr_d = addr_q;
        if (load) begin
            base_d = base_in;
            rows_d = rows_in;
            cols_d = cols_in;
            r_d    = '0;
            c_d    = '0;
        end else if (advance) begin
            if (last_col) begin
                c_d = '0;
                r_d = r_q + DIM_W'(1);
            end else begin
                c_d = c_q + DIM_W'(1);
            end
        end
        if (issue) begin
            addr_d = elem_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            rows_q <= '0;
            cols_q <= '0;
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= '0;
        end else begin
            base_q <= base_d;
            rows_q <= rows_d;
            cols_q <= cols_d;
            r_q    <= r_d;
            c_q    <= c_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/result_dump_reader.sv
// Sweeps a rectangular result region of the data memory readout port and
// streams every 12-bit word as two bytes (high nibble first) to the UART TX.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; addr_tb holds its last value
// ISSUE    | register the element address onto addr_tb
// WAIT     | RD_LAT cycles for the memory to register result
// CAPTURE  | latch result, present high byte
// SEND_HI  | hold high byte until accepted, then present low byte
// SEND_LO  | hold low byte until accepted
// ADVANCE  | step column/row, leave after the last element
// FINISH   | one-cycle done pulse
module result_dump_reader #(
    parameter int ROW_STRIDE = 64,
    parameter int RD_LAT     = 1,
    parameter int ADDR_W     = 12,
    parameter int DIM_W      = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  n_rows,
    input  logic [DIM_W-1:0]  n_cols,
    output logic [ADDR_W-1:0] addr_tb,
    input  logic [11:0]       result,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);
    import result_dump_reader_pkg::*;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [11:0] word_q, word_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        ag_load;
    logic        ag_issue;
    logic        ag_advance;
    logic        last_elem;

    dump_addr_gen #(
        .ADDR_W     (ADDR_W),
        .DIM_W      (DIM_W),
        .ROW_STRIDE (ROW_STRIDE)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .base_in   (base_addr),
        .rows_in   (n_rows),
        .cols_in   (n_cols),
        .issue     (ag_issue),
        .advance   (ag_advance),
        .addr      (addr_tb),
        .last_elem (last_elem)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        word_d     = word_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ag_load    = 1'b0;
        ag_issue   = 1'b0;
        ag_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ag_load = 1'b1;
                    if (n_rows == '0 || n_cols == '0) state_d = S_FINISH;
                    else                               state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ag_issue = 1'b1;
                wait_d   = 8'(RD_LAT - 1);
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) state_d = S_CAPTURE;
                else              wait_d  = wait_q - 8'd1;
            end
            S_CAPTURE: begin
                word_d     = result;
                tx_valid_d = 1'b1;
                tx_data_d  = {HI_PAD, result[11:8]};
                state_d    = S_SEND_HI;
            end
            S_SEND_HI: begin
                // Low byte is loaded on the accepting edge so there is no bubble.
                if (tx_ready) begin
                    tx_data_d = word_q[7:0];
                    state_d   = S_SEND_LO;
                end else begin
                    tx_data_d = {HI_PAD, word_q[11:8]};
                end
            end
            S_SEND_LO: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                ag_advance = 1'b1;
                state_d    = last_elem ? S_FINISH : S_ISSUE;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_result_dump_reader.sv
// Directed and randomized bench for result_dump_reader with a registered
// memory model and an arithmetic reference of the expected byte stream.
module tb_result_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [6:0]  n_rows;
    logic [6:0]  n_cols;
    logic [11:0] addr_tb;
    logic [11:0] result;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [4096];

    result_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .n_rows    (n_rows),
        .n_cols    (n_cols),
        .addr_tb   (addr_tb),
        .result    (result),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One-cycle registered readout port.
    always @(posedge clk) result <= mem[addr_tb];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 ready always high, 1 random ready, 2 five-cycle stall then random.
    task automatic run_dump(input logic [11:0] b, input int nr, input int nc,
                            input int mode, input int extra_start, input int abort_elem);
        int   ea[$];
        int   eb[$];
        int   hs, dn, done_cyc, stall_cnt, maxc;
        logic seen_valid, prev_stall, prev_hi, rdy, aborted;
        logic [7:0] prev_data;

        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                int a;
                a = (int'(b) + r * 64 + c) % 4096;
                ea.push_back(a);
                eb.push_back(int'(mem[a]) / 256);
                eb.push_back(int'(mem[a]) % 256);
            end
        end
        hs = 0; dn = 0; done_cyc = -1; stall_cnt = 0;
        seen_valid = 0; prev_stall = 0; prev_hi = 0; aborted = 0; prev_data = '0;
        maxc = 60 * ea.size() + 40;

        @(negedge clk);
        base_addr = b;
        n_rows    = 7'(nr);
        n_cols    = 7'(nc);
        start     = 1'b1;
        for (int cyc = 0; cyc < maxc; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0 && ea.size() > 0) chk("busy_after_start", busy, 1);
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, prev_data);
            end
            if (prev_hi) chk("no_bubble", tx_valid, 1);
            if (done === 1'b1) begin
                dn++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
            if (tx_valid === 1'b1) seen_valid = 1;
            if (abort_elem > 0 && hs == 2 * abort_elem - 1 && tx_valid === 1'b1) begin
                rst_n = 1'b0;
                #1;
                chk("rst_addr", addr_tb, 0);
                chk("rst_data", tx_data, 0);
                chk("rst_valid", tx_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                @(negedge clk);
                chk("rst_no_done", done, 0);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (tx_valid === 1'b1 && stall_cnt < 5) begin
                        rdy = 1'b0;
                        stall_cnt++;
                    end else begin
                        rdy = 1'($urandom_range(0, 1));
                    end
                end
            endcase
            tx_ready = rdy;
            if (cyc == extra_start) begin
                start     = 1'b1;
                base_addr = ~b;
                n_rows    = 7'd5;
                n_cols    = 7'd5;
            end
            prev_hi = 0;
            if (tx_valid === 1'b1 && rdy) begin
                if (hs < eb.size()) chk("byte", tx_data, eb[hs]);
                if (hs % 2 == 0) begin
                    if (hs / 2 < ea.size()) chk("addr_tb", addr_tb, ea[hs / 2]);
                    prev_hi = 1;
                end
                hs++;
            end
            prev_stall = (tx_valid === 1'b1) && !rdy;
            prev_data  = tx_data;
            if (dn > 0 && cyc >= done_cyc + 2) break;
        end
        start    = 1'b0;
        tx_ready = 1'b1;
        if (!aborted) begin
            chk("byte_count", hs, eb.size());
            chk("done_count", dn, 1);
            chk("busy_idle", busy, 0);
            if (ea.size() == 0) begin
                chk("zero_no_valid", seen_valid, 0);
                chk("zero_done_fast", (done_cyc >= 0 && done_cyc <= 2), 1);
            end else if (mode == 0) begin
                chk("throughput", done_cyc, 6 * ea.size());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
        mem[4] = 12'd1; mem[5] = 12'd2; mem[68] = 12'd3; mem[69] = 12'd4;
        mem[200] = 12'hABC;

        rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1;
        base_addr = '0; n_rows = '0; n_cols = '0;
        #23;
        chk("reset_addr", addr_tb, 0);
        chk("reset_data", tx_data, 0);
        chk("reset_valid", tx_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_dump(12'd4, 2, 2, 0, -1, 0);
        run_dump(12'd200, 1, 1, 0, -1, 0);
        run_dump(12'd300, 2, 3, 0, -1, 0);
        run_dump(12'd300, 2, 3, 2, -1, 0);
        run_dump(12'd10, 0, 3, 0, -1, 0);
        run_dump(12'd4094, 1, 4, 0, -1, 0);
        run_dump(12'd4, 2, 2, 0, -1, 2);
        run_dump(12'd4, 2, 2, 0, -1, 0);
        run_dump(12'd4, 2, 2, 0, 10, 0);
        for (int k = 0; k < 4; k++) begin
            run_dump(12'($urandom_range(0, 4095)), int'($urandom_range(1, 3)),
                     int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
